rd_wptr_sync_cmp: RTL and testbench
===================================

# rd_wptr_sync_cmp

Read-domain end of the async FIFO pointer exchange: brings the Gray-coded write pointer from the write clock domain into `RD_CLK` through a two-flop synchronizer. It compares the synchronized pointer against the read pointers and produces the raw `CMP_EMPTY` indication that the read-pointer/empty logic consumes. It also provides a registered read-side occupancy count and an almost-empty flag for downstream consumers such as frame readers and DMA engines.

## Interface
- `C_DEPTH_BITS`, 10, pointer width N; FIFO address space 2^N, usable depth 2^N-1.
- `C_AE_THRESH`, 4, almost-empty threshold in entries (0 .. 2^N-1).

- `RD_CLK` in 1: read clock.
- `RD_RST` in 1: reset RD_RST, asynchronous, active-high; clock RD_CLK.
- `WR_PTR` in N: Gray write pointer, launched from an unrelated write clock. Only one bit changes per write-clock increment.
- `RD_PTR` in N: Gray read pointer, registered in `RD_CLK`.
- `RD_PTR_P1` in N: Gray of read binary pointer + 1, registered in `RD_CLK`.
- `RD_EN` in 1: read request this cycle.
- `CMP_EMPTY` out 1: registered raw empty/going-empty compare.
- `RD_LEVEL` out N: registered occupancy, read-domain view.
- `RD_ALMOST_EMPTY` out 1: registered, high when `RD_LEVEL` <= `C_AE_THRESH`.
- `WR_PTR_SYNC` out N: synchronized Gray write pointer (second sync stage), for debug and status.

## Operation
- **Synchronizer.** `s1 <= WR_PTR; s2 <= s1` on every `RD_CLK` rising edge.
  - No logic between `WR_PTR` and `s1`.
  - `s1`/`s2` carry async-reg attributes.
  - `WR_PTR_SYNC` = `s2`.
- **Gray to binary.** Applied to both `s2` and `RD_PTR`.
  - b[N-1] = g[N-1]
  - b[i] = b[i+1] ^ g[i], for i = N-2 down to 0.
  - Purely combinational, feeding registers only.
- **Empty compare.** The next value of `CMP_EMPTY` is (`s2` == `RD_PTR`) OR (`RD_EN` AND `s2` == `RD_PTR_P1`).
  - The second term flags a read that consumes the last visible entry.
  - The result is conservative: a late write pointer only ever delays deassertion.
- **Level.** `RD_LEVEL` <= (bin(`s2`) - bin(`RD_PTR`)) mod 2^N, as N-bit unsigned subtraction with the borrow discarded (wrap is natural). Range is 0 .. 2^N-1.
- **Almost-empty.** `RD_ALMOST_EMPTY` <= (level_next <= `C_AE_THRESH`), computed from the same level_next that loads `RD_LEVEL`.
- The block drives no pointer and never stalls; all outputs update every cycle.
- **Reset values** (asynchronous, take effect immediately on `RD_RST`):
  - `s1`, `s2`, `WR_PTR_SYNC`: 0
  - `CMP_EMPTY`: 1
  - `RD_LEVEL`: 0
  - `RD_ALMOST_EMPTY`: 1
- **Release of `RD_RST`.** The first compare uses `s2` = 0, so with `RD_PTR` = 0 the block reports empty until the write pointer propagates.

## Timing
- **`WR_PTR` change to `s2`:** 2 `RD_CLK` edges. `CMP_EMPTY`, `RD_LEVEL` and `RD_ALMOST_EMPTY` reflect the change at the 3rd edge.
- **`RD_PTR` / `RD_PTR_P1` / `RD_EN` to outputs:** 1 edge.
- **Simultaneous write arrival and read (same cycle):** both are applied in the same level computation. The result is net level, with no lost update.
- **`WR_PTR` sampled mid-transition:** `s2` is either the old or the new Gray value. Both are legal, and the level is off by at most 1 in the conservative direction.
- **Wrap-around:**
  - wbin < rbin is valid; the level is taken modulo 2^N.
  - Pointer equality after a wrap means empty (full is handled in the write domain at 2^N-1).
- **Reset asserted mid-operation:** outputs go to reset values without waiting for a clock. The synchronizer restarts from 0, and `CMP_EMPTY` stays 1 until `WR_PTR` has passed through both stages after release.

## Test plan
- **Reset:** assert `RD_RST` with `WR_PTR`=0x155 between edges -> immediately `CMP_EMPTY`=1, `RD_LEVEL`=0, `RD_ALMOST_EMPTY`=1, `WR_PTR_SYNC`=0. After release, `WR_PTR_SYNC`=0x155 at the 2nd edge.
- **Latency:** `RD_PTR`=0, `RD_EN`=0; at edge 0 `WR_PTR` goes 0 -> 1 (gray of 1).
  - `CMP_EMPTY` stays 1 through edge 2, then becomes 0 at edge 3 with `RD_LEVEL`=1.
  - `RD_ALMOST_EMPTY` stays 1 (threshold 4).
- **Going-empty:** `s2` settled at gray(5)=7, `RD_PTR`=gray(4)=6, `RD_PTR_P1`=7.
  - `RD_EN`=1 -> next edge `CMP_EMPTY`=1.
  - `RD_EN`=0 -> `CMP_EMPTY`=0, `RD_LEVEL`=1.
- **Wrap** (N=4, `C_AE_THRESH`=4):
  - wbin 2 (gray 3) vs rbin 14 (gray 9) -> `RD_LEVEL`=4, `RD_ALMOST_EMPTY`=1.
  - wbin 3 (gray 2) -> `RD_LEVEL`=5, `RD_ALMOST_EMPTY`=0.
- **Max occupancy** (N=10): wbin 1023 (gray 0x200) vs `RD_PTR`=0 -> `RD_LEVEL`=1023, `CMP_EMPTY`=0.
- **Randomized async clocks** (write/read ratio 1.7 and 0.6, 10k ops) with a golden FIFO model:
  - `CMP_EMPTY` is never 0 while the model is empty.
  - `RD_LEVEL` never exceeds the model level and lags it by at most 3 `RD_CLK` cycles' worth of writes.

Source files
------------

// File: rtl/rd_wptr_sync_cmp.sv
// rd_wptr_sync_cmp: brings the Gray write pointer into RD_CLK and derives the raw
// empty compare, read-side occupancy and almost-empty flag.
module rd_wptr_sync_cmp #(
  parameter int C_DEPTH_BITS = 10,
  parameter int C_AE_THRESH  = 4
) (
  input  logic                    RD_CLK,
  input  logic                    RD_RST,
  input  logic [C_DEPTH_BITS-1:0] WR_PTR,
  input  logic [C_DEPTH_BITS-1:0] RD_PTR,
  input  logic [C_DEPTH_BITS-1:0] RD_PTR_P1,
  input  logic                    RD_EN,
  output logic                    CMP_EMPTY,
  output logic [C_DEPTH_BITS-1:0] RD_LEVEL,
  output logic                    RD_ALMOST_EMPTY,
  output logic [C_DEPTH_BITS-1:0] WR_PTR_SYNC
);
  localparam int N = C_DEPTH_BITS;
  localparam logic [N-1:0] AE_THRESH = C_AE_THRESH[N-1:0];

  // WR_PTR feeds sync1_q directly so only one Gray bit can be metastable
  (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync1_q;
  (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync2_q;
  logic [N-1:0] level_q, level_d, wbin, rbin;
  logic cmp_empty_q, cmp_empty_d, ae_q, ae_d;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    wbin        = gray2bin(sync2_q);
    rbin        = gray2bin(RD_PTR);
    level_d     = wbin - rbin;
    ae_d        = level_d <= AE_THRESH;
    cmp_empty_d = (sync2_q == RD_PTR) || (RD_EN && sync2_q == RD_PTR_P1);
  end

  always_ff @(posedge RD_CLK or posedge RD_RST) begin
    if (RD_RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cmp_empty_q <= 1'b1;
      level_q     <= '0;
      ae_q        <= 1'b1;
    end else begin
      sync1_q     <= WR_PTR;
      sync2_q     <= sync1_q;
      cmp_empty_q <= cmp_empty_d;
      level_q     <= level_d;
      ae_q        <= ae_d;
    end
  end

  assign CMP_EMPTY       = cmp_empty_q;
  assign RD_LEVEL        = level_q;
  assign RD_ALMOST_EMPTY = ae_q;
  assign WR_PTR_SYNC     = sync2_q;
endmodule

// File: tb/tb_rd_wptr_sync_cmp.sv
// tb_rd_wptr_sync_cmp: scoreboard bench for the read-domain pointer sync/compare block.
`timescale 1ns/1ps
module tb_rd_wptr_sync_cmp;
  localparam int N  = 10;
  localparam int AE = 4;

  typedef struct {
    logic         cmp;
    logic [N-1:0] lvl;
    logic         ae;
    logic [N-1:0] sync;
  } exp_t;

  logic         rd_clk = 1'b0;
  logic         rd_rst = 1'b1;
  logic [N-1:0] wr_ptr = '0;
  logic [N-1:0] rd_ptr = '0;
  logic [N-1:0] rd_ptr_p1 = '0;
  logic         rd_en = 1'b0;
  logic         cmp_empty, rd_ae;
  logic [N-1:0] rd_level, wr_ptr_sync;
  logic [3:0]   w4 = '0, r4 = '0, r4p1 = '0;
  logic         en4 = 1'b0;
  logic         cmp4, ae4;
  logic [3:0]   lvl4, sync4;

  exp_t         sb[$];
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  int           checks = 0, errors = 0;
  int           wcnt, rcnt;
  int           whist[$];
  bit           wr_done;
  logic         en_q, emp_q;

  always #5 rd_clk = ~rd_clk;

  rd_wptr_sync_cmp #(.C_DEPTH_BITS(N), .C_AE_THRESH(AE)) dut (
    .RD_CLK(rd_clk), .RD_RST(rd_rst), .WR_PTR(wr_ptr), .RD_PTR(rd_ptr),
    .RD_PTR_P1(rd_ptr_p1), .RD_EN(rd_en), .CMP_EMPTY(cmp_empty),
    .RD_LEVEL(rd_level), .RD_ALMOST_EMPTY(rd_ae), .WR_PTR_SYNC(wr_ptr_sync)
  );

  rd_wptr_sync_cmp #(.C_DEPTH_BITS(4), .C_AE_THRESH(4)) dut4 (
    .RD_CLK(rd_clk), .RD_RST(rd_rst), .WR_PTR(w4), .RD_PTR(r4),
    .RD_PTR_P1(r4p1), .RD_EN(en4), .CMP_EMPTY(cmp4),
    .RD_LEVEL(lvl4), .RD_ALMOST_EMPTY(ae4), .WR_PTR_SYNC(sync4)
  );

  function automatic logic [N-1:0] gray(input int b);
    logic [N-1:0] v;
    v = b[N-1:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = '0;
    for (int s = 0; s < N; s++) b ^= g >> s;
    return b;
  endfunction

  task automatic step(input logic [N-1:0] w, input logic [N-1:0] r,
                      input logic [N-1:0] rp1, input logic en);
    exp_t e;
    logic [N-1:0] lv;
    @(negedge rd_clk);
    wr_ptr = w; rd_ptr = r; rd_ptr_p1 = rp1; rd_en = en;
    lv = g2b(m_s2) - g2b(r);
    sb.push_back('{cmp: (m_s2 == r) || (en && m_s2 == rp1), lvl: lv,
                   ae: int'(lv) <= AE, sync: m_s1});
    m_s2 = m_s1;
    m_s1 = w;
    @(posedge rd_clk);
    #1;
    e = sb.pop_front();
    checks++; if (cmp_empty !== e.cmp) begin errors++; $display("FAIL sb_cmp_empty got %0b exp %0b", cmp_empty, e.cmp); end
    checks++; if (rd_level !== e.lvl) begin errors++; $display("FAIL sb_level got %0d exp %0d", rd_level, e.lvl); end
    checks++; if (rd_ae !== e.ae) begin errors++; $display("FAIL sb_almost_empty got %0b exp %0b", rd_ae, e.ae); end
    checks++; if (wr_ptr_sync !== e.sync) begin errors++; $display("FAIL sb_wr_ptr_sync got %h exp %h", wr_ptr_sync, e.sync); end
  endtask

  task automatic reset_dut();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    wr_ptr = '0; rd_ptr = '0; rd_ptr_p1 = gray(1); rd_en = 1'b0;
    m_s1 = '0; m_s2 = '0;
    sb.delete();
    @(posedge rd_clk);
    #1 rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge rd_clk);
    #1;
    checks++; if (cmp_empty !== 1'b1) begin errors++; $display("FAIL por_cmp_empty got %0b exp 1", cmp_empty); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL por_level got %0d exp 0", rd_level); end
    checks++; if (rd_ae !== 1'b1) begin errors++; $display("FAIL por_almost_empty got %0b exp 1", rd_ae); end
    rd_rst = 1'b0;
    repeat (4) step(gray(20), '0, gray(1), 1'b0);
    checks++; if (rd_level !== 10'd20 || cmp_empty !== 1'b0 || rd_ae !== 1'b0) begin
      errors++; $display("FAIL pre_reset_state got lvl %0d cmp %0b ae %0b exp 20 0 0", rd_level, cmp_empty, rd_ae);
    end
    @(negedge rd_clk);
    #2;
    wr_ptr = 10'h155;
    rd_rst = 1'b1;
    #1;
    checks++; if (cmp_empty !== 1'b1) begin errors++; $display("FAIL rst_cmp_empty got %0b exp 1", cmp_empty); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL rst_level got %0d exp 0", rd_level); end
    checks++; if (rd_ae !== 1'b1) begin errors++; $display("FAIL rst_almost_empty got %0b exp 1", rd_ae); end
    checks++; if (wr_ptr_sync !== '0) begin errors++; $display("FAIL rst_wr_ptr_sync got %h exp 0", wr_ptr_sync); end
    m_s1 = '0; m_s2 = '0;
    @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    step(10'h155, '0, gray(1), 1'b0);
    step(10'h155, '0, gray(1), 1'b0);
    checks++; if (wr_ptr_sync !== 10'h155) begin errors++; $display("FAIL rst_release_sync got %h exp 155", wr_ptr_sync); end
  endtask

  task automatic test_latency();
    reset_dut();
    step('0, '0, gray(1), 1'b0);
    for (int e = 1; e <= 2; e++) begin
      step(gray(1), '0, gray(1), 1'b0);
      checks++; if (cmp_empty !== 1'b1) begin errors++; $display("FAIL latency_edge%0d_cmp got %0b exp 1", e, cmp_empty); end
    end
    step(gray(1), '0, gray(1), 1'b0);
    checks++; if (cmp_empty !== 1'b0 || rd_level !== 10'd1 || rd_ae !== 1'b1) begin
      errors++; $display("FAIL latency_edge3 got cmp %0b lvl %0d ae %0b exp 0 1 1", cmp_empty, rd_level, rd_ae);
    end
  endtask

  task automatic test_going_empty();
    reset_dut();
    repeat (3) step(10'd7, 10'd6, 10'd7, 1'b0);
    checks++; if (cmp_empty !== 1'b0 || rd_level !== 10'd1) begin
      errors++; $display("FAIL ge_settled got cmp %0b lvl %0d exp 0 1", cmp_empty, rd_level);
    end
    step(10'd7, 10'd6, 10'd7, 1'b1);
    checks++; if (cmp_empty !== 1'b1) begin errors++; $display("FAIL ge_read_last got %0b exp 1", cmp_empty); end
    step(10'd7, 10'd6, 10'd7, 1'b0);
    checks++; if (cmp_empty !== 1'b0 || rd_level !== 10'd1) begin
      errors++; $display("FAIL ge_no_read got cmp %0b lvl %0d exp 0 1", cmp_empty, rd_level);
    end
  endtask

  task automatic test_wrap();
    @(negedge rd_clk);
    w4 = 4'h3; r4 = 4'h9; r4p1 = 4'h8; en4 = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    checks++; if (lvl4 !== 4'd4 || ae4 !== 1'b1 || cmp4 !== 1'b0) begin
      errors++; $display("FAIL wrap_lvl4 got lvl %0d ae %0b cmp %0b exp 4 1 0", lvl4, ae4, cmp4);
    end
    @(negedge rd_clk);
    w4 = 4'h2;
    repeat (3) @(posedge rd_clk);
    #1;
    checks++; if (lvl4 !== 4'd5 || ae4 !== 1'b0) begin
      errors++; $display("FAIL wrap_lvl5 got lvl %0d ae %0b exp 5 0", lvl4, ae4);
    end
    @(negedge rd_clk);
    w4 = 4'h9;
    repeat (3) @(posedge rd_clk);
    #1;
    checks++; if (cmp4 !== 1'b1 || lvl4 !== 4'd0 || sync4 !== 4'h9) begin
      errors++; $display("FAIL wrap_equal got cmp %0b lvl %0d sync %h exp 1 0 9", cmp4, lvl4, sync4);
    end
  endtask

  task automatic test_max();
    reset_dut();
    repeat (3) step(10'h200, '0, gray(1), 1'b0);
    checks++; if (rd_level !== 10'd1023 || cmp_empty !== 1'b0 || rd_ae !== 1'b0) begin
      errors++; $display("FAIL max_level got lvl %0d cmp %0b ae %0b exp 1023 0 0", rd_level, cmp_empty, rd_ae);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 12; i++) step(gray(i + 3), gray(i), gray(i + 1), 1'b1);
    checks++; if (rd_level !== 10'd1 || cmp_empty !== 1'b1) begin
      errors++; $display("FAIL b2b_final got lvl %0d cmp %0b exp 1 1", rd_level, cmp_empty);
    end
  endtask

  task automatic test_random_sb();
    int rb;
    reset_dut();
    for (int i = 0; i < 200; i++) begin
      rb = int'($urandom_range(0, 7));
      step(gray(int'($urandom_range(0, 7))), gray(rb), gray(rb + 1), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async(input real wper, input int ncyc);
    int lower;
    reset_dut();
    wr_done = 1'b0; wcnt = 0; rcnt = 0; whist.delete();
    en_q = 1'b0; emp_q = 1'b1;
    fork
      begin
        #0.37;
        while (!wr_done) begin
          #(wper);
          if (wcnt - rcnt < 1023 && $urandom_range(0, 7) != 0) begin
            wcnt++;
            wr_ptr = gray(wcnt);
          end
        end
      end
      begin
        for (int c = 0; c < ncyc; c++) begin
          @(posedge rd_clk);
          #1;
          checks++; if (wcnt == rcnt && cmp_empty !== 1'b1) begin
            errors++; $display("FAIL async_empty got %0b exp 1 (cycle %0d)", cmp_empty, c);
          end
          checks++; if (int'(rd_level) > wcnt - rcnt) begin
            errors++; $display("FAIL async_level_over got %0d exp <= %0d", rd_level, wcnt - rcnt);
          end
          if (whist.size() == 4) begin
            lower = whist[1] - rcnt;
            checks++; if (int'(rd_level) < lower) begin
              errors++; $display("FAIL async_level_lag got %0d exp >= %0d", rd_level, lower);
            end
          end
          if (en_q && !emp_q) begin
            rcnt++;
            rd_ptr = gray(rcnt);
            rd_ptr_p1 = gray(rcnt + 1);
          end
          emp_q = cmp_empty;
          en_q = ($urandom_range(0, 3) != 0);
          rd_en = en_q;
          whist.push_back(wcnt);
          if (whist.size() > 4) void'(whist.pop_front());
        end
        wr_done = 1'b1;
      end
    join
    checks++; if (rcnt == 0) begin errors++; $display("FAIL async_no_reads got %0d exp >0", rcnt); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_going_empty();
    test_wrap();
    test_max();
    test_back_to_back();
    test_random_sb();
    test_async(10.0 / 1.7, 3000);
    test_async(10.0 / 0.6, 3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
